// File: rtl/sched_pkg.sv
// Shared types and defaults for the frame transfer scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        READ,
        WRITE,
        FIN
    } sched_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/transfer_scheduler_if.sv
// Request/completion handshake between the scheduler and the AHB master,
// plus the buffer status flags that gate each request.
interface transfer_scheduler_if;
    logic re;
    logic we;
    logic read_complete;
    logic write_complete;
    logic rbuf_space;
    logic wbuf_avail;

    modport master (
        output re, we,
        input  read_complete, write_complete, rbuf_space, wbuf_avail
    );

    modport slave (
        input  re, we,
        output read_complete, write_complete, rbuf_space, wbuf_avail
    );
endinterface

// File: rtl/xfer_counter.sv
// Completed read/write word counters with the frame-total compares used
// by the arbiter.
module xfer_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [31:0]      total_in,
    input  logic             rd_inc,
    input  logic             wr_inc,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             rd_pending,
    output logic             wr_pending,
    output logic             wr_last
);

    // Compare at the wider of the count and total widths so neither side truncates.
    localparam int W = (CNT_W > 32) ? CNT_W : 32;

    logic [31:0]  total;
    logic [W-1:0] total_x;
    logic [W-1:0] rd_x;
    logic [W-1:0] wr_x;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            total    <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else if (load) begin
            total    <= total_in;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_inc) rd_count <= rd_count + CNT_W'(1);
            if (wr_inc) wr_count <= wr_count + CNT_W'(1);
        end
    end

    assign total_x    = W'(total);
    assign rd_x       = W'(rd_count);
    assign wr_x       = W'(wr_count);
    assign rd_pending = rd_x < total_x;
    assign wr_pending = wr_x < rd_x;
    assign wr_last    = (wr_x + W'(1)) == total_x;

endmodule

// File: rtl/transfer_scheduler.sv
// Round-robin read/write request scheduler for one frame transfer.
// Optional per-transaction watchdog enabled by defining SCHED_TIMEOUT_EN.
module transfer_scheduler
    import sched_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic [15:0]                 img_width,
    input  logic [15:0]                 img_height,
    transfer_scheduler_if.master        bus,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            wr_count,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    sched_state_t state, state_nx;
    logic         last_wr;
    logic         re_q, we_q, done_q;
    logic         re_nx, we_nx, done_nx;
    logic [31:0]  total_in;
    logic         start_ok;
    logic         rd_pending, wr_pending, wr_last;
    logic         rd_elig, wr_elig;
    logic         rd_fin, wr_fin;
    logic         timeout;

    assign total_in = 32'(img_width) * 32'(img_height);
    assign start_ok = (state == IDLE) && start;
    assign rd_elig  = bus.rbuf_space && rd_pending;
    assign wr_elig  = bus.wbuf_avail && wr_pending;
    assign rd_fin   = (state == READ)  && bus.read_complete;
    assign wr_fin   = (state == WRITE) && bus.write_complete;

    xfer_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (start_ok),
        .total_in   (total_in),
        .rd_inc     (rd_fin),
        .wr_inc     (wr_fin),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .rd_pending (rd_pending),
        .wr_pending (wr_pending),
        .wr_last    (wr_last)
    );

    // last_wr=1 means the next tie goes to read.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state   <= IDLE;
            last_wr <= 1'b1;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            re_q   <= re_nx;
            we_q   <= we_nx;
            done_q <= done_nx;
            if (start_ok)
                last_wr <= 1'b1;
            else if (state == ARB && state_nx == READ)
                last_wr <= 1'b0;
            else if (state == ARB && state_nx == WRITE)
                last_wr <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (start) state_nx = (total_in == 32'd0) ? FIN : ARB;
            ARB:
                if (rd_elig && (!wr_elig || last_wr))
                    state_nx = READ;
                else if (wr_elig)
                    state_nx = WRITE;
            READ:
                if (bus.read_complete)
                    state_nx = ARB;
                else if (timeout)
                    state_nx = FIN;
            WRITE:
                if (bus.write_complete)
                    state_nx = wr_last ? FIN : ARB;
                else if (timeout)
                    state_nx = FIN;
            FIN:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        re_nx   = (state_nx == READ);
        we_nx   = (state_nx == WRITE);
        done_nx = (state == FIN);
    end

    assign bus.re = re_q;
    assign bus.we = we_q;
    assign done   = done_q;
    assign busy   = (state != IDLE);

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Reloaded on every arbitration cycle, so it is fresh at each grant.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ARB)
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            else if (wd_cnt != '0)
                wd_cnt <= wd_cnt - WD_W'(1);
            if (start_ok)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign timeout = (wd_cnt == '0) &&
                     (((state == READ)  && !bus.read_complete) ||
                      ((state == WRITE) && !bus.write_complete));
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_transfer_scheduler.sv
// Directed bench for transfer_scheduler: cycle table plus multi-cycle sequences.
module tb_transfer_scheduler;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        busy;
    logic        done;
    logic        err;

    transfer_scheduler_if bus();

    transfer_scheduler #(.CNT_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .bus        (bus),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // in: {start, rbuf_space, wbuf_avail, read_complete, write_complete}
    // rw: {re, we}; bd: {busy, done}; values observed after the edge
    typedef struct {
        logic [4:0] in;
        logic [1:0] rw;
        int         rd;
        int         wr;
        logic [1:0] bd;
    } vec_t;

    vec_t vecs[15];

    int   grants[$];
    int   n_done, overlap, cyc, wr_hit, done_cyc, target_wr;
    int   re_age, we_age;
    logic prev_re, prev_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start               = 1'b0;
        bus.rbuf_space      = 1'b0;
        bus.wbuf_avail      = 1'b0;
        bus.read_complete   = 1'b0;
        bus.write_complete  = 1'b0;
    endtask

    task automatic reset_stats();
        grants.delete();
        n_done   = 0;
        overlap  = 0;
        cyc      = 0;
        wr_hit   = -1;
        done_cyc = -1;
        re_age   = 0;
        we_age   = 0;
        prev_re  = 1'b0;
        prev_we  = 1'b0;
    endtask

    // Completion pulse arrives in the second cycle a request is high.
    task automatic run_auto(input int max_cyc, input bit stop_on_done);
        for (int c = 0; c < max_cyc; c++) begin
            step();
            cyc++;
            if (bus.re && bus.we) overlap++;
            if (bus.re && !prev_re) grants.push_back(0);
            if (bus.we && !prev_we) grants.push_back(1);
            prev_re = bus.re;
            prev_we = bus.we;
            bus.read_complete  = bus.re && (re_age == 1);
            bus.write_complete = bus.we && (we_age == 1);
            re_age = bus.re ? re_age + 1 : 0;
            we_age = bus.we ? we_age + 1 : 0;
            if (wr_count == 32'(target_wr) && wr_hit < 0) wr_hit = cyc;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (stop_on_done) break;
            end
        end
        bus.read_complete  = 1'b0;
        bus.write_complete = 1'b0;
    endtask

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] rw,
                                input int rd, input int wr, input logic [1:0] bd);
        vec_t v;
        v.in = in; v.rw = rw; v.rd = rd; v.wr = wr; v.bd = bd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int rcnt, wcnt, cnt;
        logic [7:0] gvec;
        logic       rose;

        // 1x2 frame: stall, ignored start, stray/simultaneous completions, tie.
        vecs[0]  = mk(5'b10000, 2'b00, 0, 0, 2'b10);
        vecs[1]  = mk(5'b00000, 2'b00, 0, 0, 2'b10);
        vecs[2]  = mk(5'b01100, 2'b10, 0, 0, 2'b10);
        vecs[3]  = mk(5'b11101, 2'b10, 0, 0, 2'b10);
        vecs[4]  = mk(5'b01111, 2'b00, 1, 0, 2'b10);
        vecs[5]  = mk(5'b01100, 2'b01, 1, 0, 2'b10);
        vecs[6]  = mk(5'b01110, 2'b01, 1, 0, 2'b10);
        vecs[7]  = mk(5'b01101, 2'b00, 1, 1, 2'b10);
        vecs[8]  = mk(5'b01100, 2'b10, 1, 1, 2'b10);
        vecs[9]  = mk(5'b01010, 2'b00, 2, 1, 2'b10);
        vecs[10] = mk(5'b01000, 2'b00, 2, 1, 2'b10);
        vecs[11] = mk(5'b00100, 2'b01, 2, 1, 2'b10);
        vecs[12] = mk(5'b00101, 2'b00, 2, 2, 2'b10);
        vecs[13] = mk(5'b00000, 2'b00, 2, 2, 2'b01);
        vecs[14] = mk(5'b00000, 2'b00, 2, 2, 2'b00);

        clear_inputs();
        img_width  = 16'd1;
        img_height = 16'd2;
        n_rst = 1'b1;
        step();
        step();
        check("reset outputs", {bus.re, bus.we, busy, done, err, rd_count, wr_count}, 64'd0);
        n_rst = 1'b0;
        step();
        check("idle after reset", {busy, done}, 64'd0);

        for (int i = 0; i < 15; i++) begin
            {start, bus.rbuf_space, bus.wbuf_avail, bus.read_complete, bus.write_complete} = vecs[i].in;
            step();
            check($sformatf("vec%0d", i),
                  {bus.re, bus.we, busy, done, err, rd_count[15:0], wr_count[15:0]},
                  {vecs[i].rw, vecs[i].bd, 1'b0, vecs[i].rd[15:0], vecs[i].wr[15:0]});
        end
        clear_inputs();

        // 2x2 frame, both buffers always ready.
        img_width = 16'd2; img_height = 16'd2;
        bus.rbuf_space = 1'b1; bus.wbuf_avail = 1'b1;
        reset_stats();
        target_wr = 4;
        start = 1'b1;
        step();
        start = 1'b0;
        run_auto(200, 1'b1);
        check("2x2 grant count", 64'(grants.size()), 64'd8);
        gvec = '0;
        for (int i = 0; i < grants.size() && i < 8; i++) gvec[7-i] = grants[i][0];
        check("2x2 grant order", 64'(gvec), 64'h55);
        check("2x2 counts", {rd_count, wr_count}, {32'd4, 32'd4});
        check("2x2 done lag", 64'(done_cyc - wr_hit), 64'd1);
        check("2x2 done pulses", 64'(n_done), 64'd1);
        check("2x2 overlap", 64'(overlap), 64'd0);
        step();
        check("2x2 done drops", {busy, done}, 64'd0);
        clear_inputs();

        // Empty frame.
        img_width = 16'd0; img_height = 16'd5;
        bus.rbuf_space = 1'b1; bus.wbuf_avail = 1'b1;
        rose = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rose = rose | bus.re | bus.we;
        check("zero no early done", {busy, done}, 64'b10);
        step();
        rose = rose | bus.re | bus.we;
        check("zero done", 64'(done), 64'd1);
        step();
        rose = rose | bus.re | bus.we;
        check("zero done once", 64'(done), 64'd0);
        check("zero no requests", 64'(rose), 64'd0);
        check("zero counts", {rd_count, wr_count}, 64'd0);
        clear_inputs();

        // 1x3 frame with the result buffer initially empty.
        img_width = 16'd1; img_height = 16'd3;
        bus.rbuf_space = 1'b1; bus.wbuf_avail = 1'b0;
        reset_stats();
        target_wr = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        run_auto(30, 1'b0);
        rcnt = 0; wcnt = 0;
        foreach (grants[i]) if (grants[i] == 0) rcnt++; else wcnt++;
        check("1x3 reads", {32'(rcnt), 32'(wcnt)}, {32'd3, 32'd0});
        check("1x3 hold", {bus.re, bus.we, busy, done, rd_count}, {4'b0010, 32'd3});
        bus.wbuf_avail = 1'b1;
        grants.delete();
        run_auto(60, 1'b1);
        rcnt = 0; wcnt = 0;
        foreach (grants[i]) if (grants[i] == 0) rcnt++; else wcnt++;
        check("1x3 writes", {32'(rcnt), 32'(wcnt)}, {32'd0, 32'd3});
        check("1x3 done", {32'(n_done), wr_count}, {32'd1, 32'd3});
        step();
        clear_inputs();

        // Reset while a write is outstanding.
        img_width = 16'd1; img_height = 16'd1;
        bus.rbuf_space = 1'b1; bus.wbuf_avail = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rst pre re", 64'(bus.re), 64'd1);
        bus.read_complete = 1'b1;
        step();
        bus.read_complete = 1'b0;
        step();
        check("rst pre we", {bus.we, rd_count}, {1'b1, 32'd1});
        n_rst = 1'b1;
        step();
        check("rst mid write", {bus.re, bus.we, busy, done, rd_count, wr_count}, 64'd0);
        n_rst = 1'b0;
        clear_inputs();
        step();
        check("rst no done", {busy, done}, 64'd0);

`ifdef SCHED_TIMEOUT_EN
        // Read that never completes.
        img_width = 16'd1; img_height = 16'd1;
        bus.rbuf_space = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        cnt = bus.re ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.re) break;
            cnt++;
        end
        check("tmo re cycles", 64'(cnt), 64'd8);
        check("tmo err", {err, done}, 64'b10);
        step();
        check("tmo done", 64'(done), 64'd1);
        step();
        check("tmo end", {err, busy, done, rd_count}, {3'b100, 32'd0});
        clear_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transfer_scheduler.md
TRANSFER_SCHEDULER -- requirements
Module: transfer_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the pixel-word counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: watchdog limit per transaction, used only under SCHED_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port n_rst, input, 1: synchronous, active-high reset despite the name; asserted high, sampled on clk.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a frame transfer.
REQ-006 SHALL have ports img_width and img_height, input, 16 each: frame size in pixel words.
REQ-007 SHALL have port rbuf_space, input, 1: the input buffer can accept one read word.
REQ-008 SHALL have port wbuf_avail, input, 1: the result buffer holds one word ready to write.
REQ-009 SHALL have ports read_complete and write_complete, input, 1 each: AHB master single-cycle completion pulses.
REQ-010 SHALL have ports re and we, output, 1 each: requests to the AHB master.
REQ-011 SHALL have ports rd_count and wr_count, output, CNT_W each: completed read and write words.
REQ-012 SHALL have ports busy, done and err, output, 1 each: transfer active, one-cycle frame-end pulse, and sticky timeout flag.

Function
REQ-013 SHALL use states IDLE, ARB, READ, WRITE and FIN.
REQ-014 SHALL, in IDLE on start: latch total = img_width*img_height (32-bit unsigned product), clear both counts and err, and go to ARB.
REQ-015 SHALL go from IDLE directly to FIN when total is 0.
REQ-016 SHALL treat a read as eligible when rbuf_space=1 and rd_count<total.
REQ-017 SHALL treat a write as eligible when wbuf_avail=1 and wr_count<rd_count.
REQ-018 SHALL, in ARB, grant the only eligible side; when both are eligible, grant the side not granted last (round-robin); the first tie after start goes to read.
REQ-019 SHALL, in ARB with nothing eligible, stay in ARB.
REQ-020 SHALL assert re in READ and we in WRITE, registered, from the cycle after the grant until the completion pulse arrives.
REQ-021 SHALL keep at most one transaction outstanding; re and we are never high together.
REQ-022 SHALL, on the matching completion: drop the request in that cycle's next edge, increment the matching count by 1, and return to ARB.
REQ-023 SHALL ignore a non-matching completion pulse, including one that arrives simultaneously with the matching pulse.
REQ-024 SHALL go to FIN when wr_count reaches total.
REQ-025 SHALL, in FIN, pulse done for exactly one cycle and return to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL hold rd_count, wr_count and err in IDLE until the next accepted start.

Reset
REQ-029 SHALL, while n_rst=1 at a clk edge, force state=IDLE, re=0, we=0, done=0, busy=0, err=0, rd_count=0, wr_count=0, and clear round-robin history to read-first.
REQ-030 SHALL abandon any outstanding request on reset mid-transfer, with no done pulse.

Configuration
REQ-031 SHALL, with SCHED_TIMEOUT_EN defined, count cycles in READ or WRITE; on reaching TIMEOUT_CYCLES without completion it sets err=1, drops the request, and goes to FIN (done still pulses).
REQ-032 SHALL, without SCHED_TIMEOUT_EN, contain no watchdog logic, wait indefinitely for completion, and tie err to 0.

Structure
REQ-033 SHALL import a shared package sched_pkg holding the state enum typedef and the default TIMEOUT_CYCLES constant.
REQ-034 SHALL place the rd_count/wr_count pair with increment and compare logic in one sub-module, xfer_counter.

Verification
REQ-035 SHALL cover a 2x2 frame with rbuf_space=1, wbuf_avail=1 and completion 1 cycle after each request: grants R,W,R,W,R,W,R,W; done one cycle after wr_count=4.
REQ-036 SHALL cover width=0, height=5 with start: done pulses two cycles later, re and we never rise.
REQ-037 SHALL cover a 1x3 frame with wbuf_avail=0: exactly 3 reads, then ARB holds; raising wbuf_avail gives 3 writes, then done.
REQ-038 SHALL cover read_complete and write_complete together during READ: rd_count +1 and wr_count unchanged.
REQ-039 SHALL cover n_rst=1 asserted in WRITE with we=1: we=0 and all counts 0 next edge, no done.
REQ-040 SHALL cover, with SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read that never completes: re drops after 8 cycles, err=1, done pulses once.
